// File: rtl/led_sequence_ctrl.sv
// led_sequence_ctrl: plays a run-time loaded table of (LED pattern, duration)
// steps on the 8 user LEDs, either once or in a loop.
module led_sequence_ctrl #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int STEPS    = 8,
    parameter int DUR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(STEPS)-1:0] cfg_addr,
    input  logic [7:0]               cfg_pattern,
    input  logic [DUR_W-1:0]         cfg_dur,
    input  logic [$clog2(STEPS):0]   seq_len,
    input  logic                     loop_en,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    output logic [7:0]               leds,
    output logic                     busy,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int IDX_W    = $clog2(STEPS);
    localparam int PS_W     = $clog2(TICK_DIV);

    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [IDX_W:0]   LEN_MAX = (IDX_W + 1)'(STEPS);
    localparam logic [IDX_W:0]   LEN_ONE = (IDX_W + 1)'(1);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [7:0]        leds_q;
    logic              busy_q;
    logic [IDX_W-1:0]  step_idx_q;
    logic              done_q;
    logic              cfg_err_q;
    logic [PS_W-1:0]   ps_q;
    logic [DUR_W-1:0]  rem_q;
    logic [IDX_W:0]    len_q;
    logic              loop_q;

    // Step table; intentionally not reset, contents are loaded before use.
    logic [7:0]        pat_mem [STEPS];
    logic [DUR_W-1:0]  dur_mem [STEPS];

    logic              tick;
    logic              last_step;
    logic              len_ok;

    // Prescaler terminal count, last-step detect and start-length validation.
    always_comb begin
        tick      = (ps_q == PS_LAST);
        last_step = ({1'b0, step_idx_q} == (len_q - LEN_ONE));
        len_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
    end

    // Table writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == IDLE)) begin
            pat_mem[cfg_addr] <= cfg_pattern;
            dur_mem[cfg_addr] <= cfg_dur;
        end
    end

    // Sequencer FSM with registered outputs; stop overrides every other action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            leds_q     <= '0;
            busy_q     <= 1'b0;
            step_idx_q <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            ps_q       <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= cfg_we && (state_q != IDLE);
            if (cmd_stop) begin
                state_q    <= IDLE;
                leds_q     <= '0;
                busy_q     <= 1'b0;
                step_idx_q <= '0;
                ps_q       <= '0;
                rem_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        leds_q <= '0;
                        busy_q <= 1'b0;
                        if (cmd_start) begin
                            if (len_ok) begin
                                len_q      <= seq_len;
                                loop_q     <= loop_en;
                                step_idx_q <= '0;
                                busy_q     <= 1'b1;
                                state_q    <= LOAD;
                            end else begin
                                cfg_err_q  <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        leds_q  <= pat_mem[step_idx_q];
                        rem_q   <= (dur_mem[step_idx_q] == '0) ? DUR_ONE : dur_mem[step_idx_q];
                        ps_q    <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        if (tick) begin
                            ps_q  <= '0;
                            rem_q <= rem_q - DUR_ONE;
                            if (rem_q == DUR_ONE) begin
                                if (!last_step) begin
                                    step_idx_q <= step_idx_q + IDX_ONE;
                                    state_q    <= LOAD;
                                end else if (loop_q) begin
                                    step_idx_q <= '0;
                                    state_q    <= LOAD;
                                end else begin
                                    leds_q  <= '0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end
                            end
                        end else begin
                            ps_q <= ps_q + PS_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign leds     = leds_q;
    assign busy     = busy_q;
    assign step_idx = step_idx_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule
